// File: rtl/lab1_imul_pkg.sv
// ============================================================================
// Module  : lab1_imul_pkg
// Brief   : Shared types and constants for the variable-latency multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lab1_imul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SHAMT_W  = 4;
    localparam int SKIP_MAX = 8;

endpackage

`default_nettype wire

// File: rtl/lab1_imul_calc_shamt.sv
// ============================================================================
// Module  : lab1_imul_calc_shamt
// Brief   : Zero-skip shift amount from the low byte of the multiplier operand.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lab1_imul_calc_shamt
    import lab1_imul_pkg::*;
(
    input  logic [7:0]         in_byte,
    output logic [SHAMT_W-1:0] shamt
);

    always_comb begin
        shamt = SHAMT_W'(1);
        if (in_byte == 8'd0) begin
            shamt = SHAMT_W'(SKIP_MAX);
        end else if (!in_byte[0]) begin
            // Descending scan so the lowest set bit wins.
            for (int i = 7; i >= 1; i--) begin
                if (in_byte[i]) begin
                    shamt = SHAMT_W'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lab1_imul_int_mul_var_lat.sv
// ============================================================================
// Module  : lab1_imul_int_mul_var_lat
// Brief   : Iterative val/rdy multiplier; LAB1_IMUL_ZERO_SKIP_EN enables zero skipping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lab1_imul_int_mul_var_lat
    import lab1_imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2*NBITS-1:0] req_msg,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [NBITS-1:0]   resp_msg
);

    state_t               state;
    state_t               state_next;
    logic [NBITS-1:0]     a_reg;
    logic [NBITS-1:0]     b_reg;
    logic [NBITS-1:0]     result_reg;
    logic [SHAMT_W-1:0]   shamt;

`ifdef LAB1_IMUL_ZERO_SKIP_EN
    lab1_imul_calc_shamt u_calc_shamt (
        .in_byte (b_reg[7:0]),
        .shamt   (shamt)
    );
`else
    assign shamt = SHAMT_W'(1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_val)       state_next = CALC;
            CALC:    if (b_reg == '0)   state_next = DONE;
            DONE:    if (resp_rdy)      state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
        end else if (state == IDLE && req_val) begin
            a_reg      <= req_msg[2*NBITS-1:NBITS];
            b_reg      <= req_msg[NBITS-1:0];
            result_reg <= '0;
        end else if (state == CALC && b_reg != '0) begin
            if (b_reg[0]) begin
                result_reg <= result_reg + a_reg;
            end
            a_reg <= a_reg << shamt;
            b_reg <= b_reg >> shamt;
        end
    end

    assign req_rdy  = (state == IDLE);
    assign resp_val = (state == DONE);
    // Gated so the partial sum never leaks out while iterating.
    assign resp_msg = (state == DONE) ? result_reg : '0;

endmodule

`default_nettype wire

// File: tb/tb_lab1_imul_int_mul_var_lat.sv
// ============================================================================
// Module  : tb_lab1_imul_int_mul_var_lat
// Brief   : Randomized self-checking bench against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lab1_imul_int_mul_var_lat;

    localparam int NBITS = 32;

    logic               clk      = 1'b0;
    logic               reset_n  = 1'b0;
    logic               req_val  = 1'b0;
    logic [2*NBITS-1:0] req_msg  = '0;
    logic               resp_rdy = 1'b1;
    logic               req_rdy;
    logic               resp_val;
    logic [NBITS-1:0]   resp_msg;

    int checks = 0;
    int errors = 0;

    lab1_imul_int_mul_var_lat #(.NBITS(NBITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected number of CALC cycles, including the final zero-detect cycle.
    function automatic int exp_calc_cycles(input logic [31:0] b);
        int n;
        logic [31:0] v;
        n = 1;
        v = b;
`ifdef LAB1_IMUL_ZERO_SKIP_EN
        while (v != 0) begin
            int k;
            k = 0;
            while (k < 8 && v[k] == 1'b0) k++;
            if (k == 0) k = 1;
            v = v >> k;
            n++;
        end
`else
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 2;
`endif
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_val && n < 200) begin
            step();
            n++;
        end
        check("resp_val_timeout", 64'(resp_val), 64'd1);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int stall);
        int n;
        int guard;
        logic [31:0] exp;
        exp   = a * b;
        guard = 0;
        while (!req_rdy && guard < 200) begin
            step();
            guard++;
        end
        check("req_rdy_idle", 64'(req_rdy), 64'd1);
        req_val  = 1'b1;
        req_msg  = {a, b};
        resp_rdy = (stall == 0);
        step();
        req_val = 1'b0;
        req_msg = {$urandom, $urandom};
        wait_resp(n);
        check("latency", 64'(n), 64'(exp_calc_cycles(b)));
        check("resp_msg", 64'(resp_msg), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            check("stall_val", 64'(resp_val), 64'd1);
            check("stall_msg", 64'(resp_msg), 64'(exp));
            check("stall_req_rdy", 64'(req_rdy), 64'd0);
            step();
        end
        resp_rdy = 1'b1;
        step();
        check("post_hs_val", 64'(resp_val), 64'd0);
        check("post_hs_rdy", 64'(req_rdy), 64'd1);
    endtask

    initial begin
        int n;
        #1;
        check("rst_req_rdy", 64'(req_rdy), 64'd1);
        check("rst_resp_val", 64'(resp_val), 64'd0);
        check("rst_resp_msg", 64'(resp_msg), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("idle_req_rdy", 64'(req_rdy), 64'd1);

        run_txn(32'd3, 32'd5, 0);
        run_txn(32'd7, 32'd0, 0);
        run_txn(32'd0, 32'hFF, 0);
        run_txn(32'd1, 32'h8000_0000, 0);
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_txn(32'h8000_0000, 32'd2, 0);
        run_txn(32'd123, 32'd456, 5);

        // Request presented in the handshake cycle is taken one cycle later.
        req_val = 1'b1;
        req_msg = {32'd10, 32'd11};
        step();
        req_val = 1'b0;
        wait_resp(n);
        check("b2b_first", 64'(resp_msg), 64'd110);
        req_val  = 1'b1;
        req_msg  = {32'd12, 32'd13};
        resp_rdy = 1'b1;
        step();
        check("b2b_idle_rdy", 64'(req_rdy), 64'd1);
        check("b2b_idle_val", 64'(resp_val), 64'd0);
        step();
        req_val = 1'b0;
        check("b2b_accepted", 64'(req_rdy), 64'd0);
        wait_resp(n);
        check("b2b_second", 64'(resp_msg), 64'd156);
        step();

        // Asynchronous reset during CALC abandons the transaction.
        req_val = 1'b1;
        req_msg = {32'd9, 32'd9};
        step();
        req_val = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_req_rdy", 64'(req_rdy), 64'd1);
        check("midrst_resp_val", 64'(resp_val), 64'd0);
        check("midrst_resp_msg", 64'(resp_msg), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        check("after_rst_val", 64'(resp_val), 64'd0);
        run_txn(32'd6, 32'd7, 0);

        for (int t = 0; t < 30; t++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 255);
                1:       rb = 32'd1 << $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_txn(ra, rb, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lab1_imul_int_mul_var_lat.md
Name: lab1_imul_int_mul_var_lat

Overview:
- Iterative variable-latency 32-bit integer multiplier with val/rdy request and response interfaces.
- Consumes the shift amount produced by the zero-skip shift-amount stage (lab1_imul_calc_shamt) to advance over runs of zero bits in the multiplier operand.
- Sits between the test source and sink (or processor MDU port); returns the low NBITS of a*b.

Parameters:
- NBITS, 32, operand and result width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_msg  in  2*NBITS  operand a in [2*NBITS-1:NBITS], operand b in [NBITS-1:0]
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_msg  out  NBITS  product, low NBITS of a*b

Behaviour:
- Reset:
  - Asynchronous assertion (reset_n=0) forces state=IDLE and clears a_reg, b_reg and result_reg to 0.
  - Outputs during and after reset: req_rdy=1, resp_val=0, resp_msg=0.
  - Reset mid-operation (CALC or DONE) abandons the transaction; no response is produced.
- FSM states IDLE, CALC, DONE; all outputs decode from state and registers only (Moore).
- IDLE:
  - req_rdy=1.
  - On req_val&req_rdy: a_reg<=a, b_reg<=b, result_reg<=0, next state CALC.
- CALC (one iteration per cycle):
  - If b_reg==0: next state DONE; registers hold.
  - Else:
    - If b_reg[0]: result_reg += a_reg (mod 2^NBITS).
    - a_reg <<= shamt, discarding overflow bits; b_reg >>= shamt, zero-filled.
- shamt (4 bits) is computed from b_reg[7:0]:
  - 8 if the byte is 0.
  - 1 if bit0 is set.
  - Otherwise the index of the lowest set bit (bit1 gives 1, bit2 gives 2, ..., bit7 gives 7).
- DONE:
  - resp_val=1; resp_msg=result_reg, stable while in DONE.
  - On resp_rdy: next state IDLE. Stall indefinitely while resp_rdy=0.
- req_rdy=0 in CALC and DONE. A new request is accepted no earlier than the cycle after the response handshake (no same-cycle overlap).
- Latency: 1 accept cycle + N CALC cycles (N includes the final b_reg==0 detect cycle) + at least 1 DONE cycle.
- Boundary cases:
  - b=0: one CALC cycle, result 0.
  - a=0 with b≠0: iterations still run, result 0.
  - Overflow wraps modulo 2^NBITS.
- req_msg is ignored outside IDLE.

Optional Feature:
- LAB1_IMUL_ZERO_SKIP_EN
  - Defined: shamt comes from the zero-skip rule above (variable latency, at most 8 bits skipped per cycle).
  - Undefined: shamt is constant 1 and lab1_imul_calc_shamt is not instantiated. Early termination on b_reg==0 is retained. Results are identical in both builds; only latency differs.

Decomposition:
- Package lab1_imul_pkg:
  - State enum typedef (IDLE, CALC, DONE).
  - Constant SHAMT_W=4.
  - Constant SKIP_MAX=8.
- Sub-module lab1_imul_calc_shamt:
  - Combinational: 8-bit input, 4-bit output, implementing the shamt rule.
  - Instantiated only under LAB1_IMUL_ZERO_SKIP_EN.
- Remaining logic (control FSM plus datapath registers, adder and shifters) stays in the top module.

Test Plan:
- a=3, b=5, resp_rdy=1 -> resp_msg=15. With ZERO_SKIP: 4 CALC cycles, resp_val high on the 5th cycle after accept.
- a=7, b=0 -> resp_msg=0 after exactly 1 CALC cycle. a=0, b=0xFF -> 0.
- a=1, b=0x80000000 -> resp_msg=0x80000000:
  - ZERO_SKIP defined: 6 CALC cycles.
  - ZERO_SKIP undefined: 33 CALC cycles.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_msg=0x00000001 (wrap); a=0x80000000, b=2 -> 0.
- Sink holds resp_rdy=0 for 5 cycles in DONE -> resp_val and resp_msg stable, req_rdy=0. Back-to-back request presented in the handshake cycle is accepted the following cycle.
- reset_n pulsed low during CALC of a=9, b=9 -> immediately req_rdy=1, resp_val=0, resp_msg=0. Next request a=6, b=7 -> 42.
